// File: rtl/proc_control_fsm.sv
// Multi-cycle control unit for the 10-bit immediate-capable processor.
// Each instruction runs through T0..T3; outputs are registered from the next state and IR.
module proc_control_fsm #(
   parameter int DATA_W = 10,
   parameter int REG_AW = 2
) (
   input  logic              CLKb,
   input  logic              RSTb,
   input  logic              EXEC,
   input  logic [DATA_W-1:0] INSTR,
   output logic              ENW,
   output logic [REG_AW-1:0] WRA,
   output logic              ENR0,
   output logic [REG_AW-1:0] RDA0,
   output logic [REG_AW-1:0] RDA1,
   output logic [1:0]        BUSSEL,
   output logic [DATA_W-1:0] IMM,
   output logic              ENA,
   output logic              ENG,
   output logic              ALUOP,
   output logic              BUSY,
   output logic              DONE
);

   typedef enum logic [1:0] {
      T0 = 2'd0,
      T1 = 2'd1,
      T2 = 2'd2,
      T3 = 2'd3
   } state_t;

   typedef struct packed {
      logic              enw;
      logic [REG_AW-1:0] wra;
      logic              enr0;
      logic [REG_AW-1:0] rda0;
      logic [REG_AW-1:0] rda1;
      logic [1:0]        bussel;
      logic [DATA_W-1:0] imm;
      logic              ena;
      logic              eng;
      logic              aluop;
      logic              busy;
      logic              done;
   } out_t;

   localparam logic [3:0] OP_LOAD = 4'd0;
   localparam logic [3:0] OP_COPY = 4'd1;
   localparam logic [3:0] OP_ADD  = 4'd2;
   localparam logic [3:0] OP_SUB  = 4'd3;
   localparam logic [3:0] OP_ADDI = 4'd4;
   localparam logic [3:0] OP_SUBI = 4'd5;

   localparam logic [1:0] BUS_Q0  = 2'b00;
   localparam logic [1:0] BUS_DIN = 2'b01;
   localparam logic [1:0] BUS_G   = 2'b10;
   localparam logic [1:0] BUS_IMM = 2'b11;

   state_t            r_state;
   state_t            w_state_next;
   logic [DATA_W-1:0] r_ir;
   logic [DATA_W-1:0] w_ir_next;
   out_t              r_out;
   logic              w_unused;

   function automatic logic is_alu(input logic [3:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI) || (op == OP_SUBI);
   endfunction

   // Moore output decode; every field not driven below stays 0.
   function automatic out_t decode(input state_t st, input logic [DATA_W-1:0] ir);
      out_t              o;
      logic [3:0]        op;
      logic [REG_AW-1:0] rx;
      logic [REG_AW-1:0] ry;
      o      = '0;
      op     = ir[9:6];
      rx     = ir[4:3];
      ry     = ir[1:0];
      o.rda1 = ry;
      case (st)
         T0: o.busy = 1'b0;
         T1: begin
            o.busy = 1'b1;
            case (op)
               OP_LOAD: begin
                  o.bussel = BUS_DIN;
                  o.enw    = 1'b1;
                  o.wra    = rx;
                  o.done   = 1'b1;
               end
               OP_COPY: begin
                  o.enr0   = 1'b1;
                  o.rda0   = ry;
                  o.bussel = BUS_Q0;
                  o.enw    = 1'b1;
                  o.wra    = rx;
                  o.done   = 1'b1;
               end
               OP_ADD, OP_SUB, OP_ADDI, OP_SUBI: begin
                  o.enr0   = 1'b1;
                  o.rda0   = rx;
                  o.bussel = BUS_Q0;
                  o.ena    = 1'b1;
               end
               default: o.done = 1'b1;
            endcase
         end
         T2: begin
            o.busy = 1'b1;
            case (op)
               OP_ADD, OP_SUB: begin
                  o.enr0   = 1'b1;
                  o.rda0   = ry;
                  o.bussel = BUS_Q0;
                  o.eng    = 1'b1;
                  o.aluop  = op[0];
               end
               OP_ADDI, OP_SUBI: begin
                  o.bussel = BUS_IMM;
                  o.imm    = {{(DATA_W-3){1'b0}}, ir[2:0]};
                  o.eng    = 1'b1;
                  o.aluop  = op[0];
               end
               default: o.busy = 1'b1;
            endcase
         end
         T3: begin
            o.busy   = 1'b1;
            o.bussel = BUS_G;
            o.enw    = 1'b1;
            o.wra    = rx;
            o.done   = 1'b1;
         end
         default: o = '0;
      endcase
      return o;
   endfunction

   // Next state and instruction capture; EXEC only matters in T0.
   always_comb begin
      w_state_next = r_state;
      w_ir_next    = r_ir;
      case (r_state)
         T0: begin
            if (EXEC) begin
               w_ir_next    = INSTR;
               w_state_next = T1;
            end else begin
               w_state_next = T0;
            end
         end
         T1: begin
            if (is_alu(r_ir[9:6])) begin
               w_state_next = T2;
            end else begin
               w_state_next = T0;
            end
         end
         T2:      w_state_next = T3;
         T3:      w_state_next = T0;
         default: w_state_next = T0;
      endcase
   end

   // State, IR and output registers; outputs are pre-decoded so they line up with the state.
   always_ff @(posedge CLKb or negedge RSTb) begin
      if (!RSTb) begin
         r_state <= T0;
         r_ir    <= '0;
         r_out   <= '0;
      end else begin
         r_state <= w_state_next;
         r_ir    <= w_ir_next;
         r_out   <= decode(w_state_next, w_ir_next);
      end
   end

   // IR[5] is the unused top bit of the X field.
   assign w_unused = r_ir[5];

   assign ENW    = r_out.enw;
   assign WRA    = r_out.wra;
   assign ENR0   = r_out.enr0;
   assign RDA0   = r_out.rda0;
   assign RDA1   = r_out.rda1;
   assign BUSSEL = r_out.bussel;
   assign IMM    = r_out.imm;
   assign ENA    = r_out.ena;
   assign ENG    = r_out.eng;
   assign ALUOP  = r_out.aluop;
   assign BUSY   = r_out.busy;
   assign DONE   = r_out.done;

endmodule

// File: tb/tb_proc_control_fsm.sv
// Directed bench for proc_control_fsm: every cycle's full output vector is compared
// against hand-computed values.
module tb_proc_control_fsm;

   logic       CLKb;
   logic       RSTb;
   logic       EXEC;
   logic [9:0] INSTR;
   logic       ENW;
   logic [1:0] WRA;
   logic       ENR0;
   logic [1:0] RDA0;
   logic [1:0] RDA1;
   logic [1:0] BUSSEL;
   logic [9:0] IMM;
   logic       ENA;
   logic       ENG;
   logic       ALUOP;
   logic       BUSY;
   logic       DONE;

   int checks   = 0;
   int failures = 0;

   proc_control_fsm #(.DATA_W(10), .REG_AW(2)) dut (
      .CLKb(CLKb), .RSTb(RSTb), .EXEC(EXEC), .INSTR(INSTR),
      .ENW(ENW), .WRA(WRA), .ENR0(ENR0), .RDA0(RDA0), .RDA1(RDA1),
      .BUSSEL(BUSSEL), .IMM(IMM), .ENA(ENA), .ENG(ENG), .ALUOP(ALUOP),
      .BUSY(BUSY), .DONE(DONE)
   );

   initial CLKb = 1'b0;
   always #5 CLKb = ~CLKb;

   // Packing order: ENW WRA ENR0 RDA0 RDA1 BUSSEL IMM ENA ENG ALUOP BUSY DONE
   function automatic logic [24:0] ov(input logic enw, input logic [1:0] wra,
                                      input logic enr0, input logic [1:0] rda0,
                                      input logic [1:0] rda1, input logic [1:0] bussel,
                                      input logic [9:0] imm, input logic ena,
                                      input logic eng, input logic aluop,
                                      input logic busy, input logic done);
      return {enw, wra, enr0, rda0, rda1, bussel, imm, ena, eng, aluop, busy, done};
   endfunction

   task automatic chk(input string tag, input logic [24:0] obs, input logic [24:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge CLKb);
      #1;
   endtask

   logic [24:0] w_obs;
   assign w_obs = {ENW, WRA, ENR0, RDA0, RDA1, BUSSEL, IMM, ENA, ENG, ALUOP, BUSY, DONE};

   initial begin
      RSTb  = 1'b0;
      EXEC  = 1'b0;
      INSTR = 10'd0;
      #12;
      chk("reset_init", w_obs, 25'd0);
      @(negedge CLKb);
      RSTb = 1'b1;
      cyc();
      chk("idle", w_obs, 25'd0);

      // LOAD R2
      INSTR = 10'b0000_010_000; EXEC = 1'b1;
      cyc();
      chk("load_t1", w_obs, ov(1'b1, 2'd2, 1'b0, 2'd0, 2'd0, 2'b01, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
      EXEC = 1'b0;
      cyc();
      chk("load_t0", w_obs, 25'd0);

      // COPY R3 <- R1
      INSTR = 10'b0001_011_001; EXEC = 1'b1;
      cyc();
      chk("copy_t1", w_obs, ov(1'b1, 2'd3, 1'b1, 2'd1, 2'd1, 2'b00, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
      EXEC = 1'b0;
      cyc();
      chk("copy_t0", w_obs, ov(1'b0, 2'd0, 1'b0, 2'd0, 2'd1, 2'b00, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

      // SUB R0 <- R0 - R2
      INSTR = 10'b0011_000_010; EXEC = 1'b1;
      cyc();
      chk("sub_t1", w_obs, ov(1'b0, 2'd0, 1'b1, 2'd0, 2'd2, 2'b00, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
      EXEC = 1'b0;
      cyc();
      chk("sub_t2", w_obs, ov(1'b0, 2'd0, 1'b1, 2'd2, 2'd2, 2'b00, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
      cyc();
      chk("sub_t3", w_obs, ov(1'b1, 2'd0, 1'b0, 2'd0, 2'd2, 2'b10, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
      cyc();
      chk("sub_t0", w_obs, ov(1'b0, 2'd0, 1'b0, 2'd0, 2'd2, 2'b00, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

      // ADDI R1 += 5, with INSTR and EXEC disturbed while busy
      INSTR = 10'b0100_001_101; EXEC = 1'b1;
      cyc();
      chk("addi_t1", w_obs, ov(1'b0, 2'd0, 1'b1, 2'd1, 2'd1, 2'b00, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
      INSTR = 10'b0001_110_010;
      cyc();
      chk("addi_t2", w_obs, ov(1'b0, 2'd0, 1'b0, 2'd0, 2'd1, 2'b11, 10'd5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
      INSTR = 10'b0011_011_111;
      cyc();
      chk("addi_t3", w_obs, ov(1'b1, 2'd1, 1'b0, 2'd0, 2'd1, 2'b10, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
      EXEC = 1'b0;
      cyc();
      chk("addi_t0", w_obs, ov(1'b0, 2'd0, 1'b0, 2'd0, 2'd1, 2'b00, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

      // Back-to-back: LOAD R1 then undefined opcode 1111 (NOP) with EXEC held high
      INSTR = 10'b0000_001_000; EXEC = 1'b1;
      cyc();
      chk("b2b_load_t1", w_obs, ov(1'b1, 2'd1, 1'b0, 2'd0, 2'd0, 2'b01, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
      INSTR = 10'b1111_000_011;
      cyc();
      chk("b2b_gap_t0", w_obs, 25'd0);
      cyc();
      chk("b2b_nop_t1", w_obs, ov(1'b0, 2'd0, 1'b0, 2'd0, 2'd3, 2'b00, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
      EXEC = 1'b0;
      cyc();
      chk("b2b_nop_t0", w_obs, ov(1'b0, 2'd0, 1'b0, 2'd0, 2'd3, 2'b00, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));

      // ADD R2 += R3, reset asserted mid-T2
      INSTR = 10'b0010_010_011; EXEC = 1'b1;
      cyc();
      chk("add_t1", w_obs, ov(1'b0, 2'd0, 1'b1, 2'd2, 2'd3, 2'b00, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
      EXEC = 1'b0;
      cyc();
      chk("add_t2", w_obs, ov(1'b0, 2'd0, 1'b1, 2'd3, 2'd3, 2'b00, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
      RSTb = 1'b0;
      #1;
      chk("reset_async", w_obs, 25'd0);
      @(negedge CLKb);
      RSTb = 1'b1;
      cyc();
      chk("post_reset_1", w_obs, 25'd0);
      cyc();
      chk("post_reset_2", w_obs, 25'd0);

      // SUBI R3 -= 7 after reset, exercising the immediate path with ALUOP = 1
      INSTR = 10'b0101_011_111; EXEC = 1'b1;
      cyc();
      EXEC = 1'b0;
      chk("subi_t1", w_obs, ov(1'b0, 2'd0, 1'b1, 2'd3, 2'd3, 2'b00, 10'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
      cyc();
      chk("subi_t2", w_obs, ov(1'b0, 2'd0, 1'b0, 2'd0, 2'd3, 2'b11, 10'd7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0));
      cyc();
      chk("subi_t3", w_obs, ov(1'b1, 2'd3, 1'b0, 2'd0, 2'd3, 2'b10, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/proc_control_fsm.md
Name: proc_control_fsm

Overview:
- Multi-cycle control unit for the 10-bit processor with immediate instructions.
- Sits directly upstream of the 4x10 register file and drives its write enable, write address, read enable and read addresses.
- Also drives the shared data-bus source select, the ALU operand/result latch enables and the ALU op.
- Latches one instruction word on EXEC, sequences it through T0..T3, and pulses DONE on the final cycle.

Parameters:
DATA_W, 10, instruction/data width
REG_AW, 2, register address width (4 registers)

Ports:
CLKb  in  1  system clock; all state updates on rising edge
RSTb  in  1  asynchronous active-low reset
EXEC  in  1  start request; sampled only in T0
INSTR  in  DATA_W  instruction word; sampled with EXEC in T0
ENW  out  1  register-file write enable
WRA  out  REG_AW  register-file write address
ENR0  out  1  register-file port-0 read enable (Q0 drives bus only when high)
RDA0  out  REG_AW  port-0 read address
RDA1  out  REG_AW  port-1 read address
BUSSEL  out  2  bus source: 00 = Q0, 01 = external DIN, 10 = ALU result G, 11 = immediate
IMM  out  DATA_W  zero-extended immediate
ENA  out  1  ALU operand-A latch enable
ENG  out  1  ALU result-G latch enable
ALUOP  out  1  0 = add, 1 = subtract
BUSY  out  1  instruction in progress
DONE  out  1  one-cycle pulse on the final cycle of an instruction

Behaviour:
- Reset, asynchronous on RSTb low:
  - state = T0, IR = 0.
  - All outputs 0; RDA1 = 0.
  - Reset asserted mid-instruction aborts it; no ENW after reset.
- Instruction format (IR):
  - Opcode = IR[9:6].
  - X field = IR[5:3]; register Rx = IR[4:3].
  - Y field = IR[2:0]; register Ry = IR[1:0].
  - IMM = {7'b0, IR[2:0]}.
- Opcodes:
  - 0000 LOAD: Rx <- DIN
  - 0001 COPY: Rx <- Ry
  - 0010 ADD: Rx <- Rx + Ry
  - 0011 SUB: Rx <- Rx - Ry
  - 0100 ADDI: Rx <- Rx + imm3
  - 0101 SUBI: Rx <- Rx - imm3
  - All others: NOP.
- Outputs are Moore-style, decoded from state and IR only (never from the live INSTR).
- Unlisted outputs are 0 in every state.
- RDA1 = Ry at all times after capture.
- T0 (idle):
  - BUSY = 0.
  - If EXEC = 1: IR <= INSTR, next state T1. Otherwise stay in T0.
- T1 (BUSY = 1):
  - LOAD: BUSSEL = 01, ENW = 1, WRA = Rx, DONE = 1, next T0.
  - COPY: ENR0 = 1, RDA0 = Ry, BUSSEL = 00, ENW = 1, WRA = Rx, DONE = 1, next T0.
  - ADD/SUB/ADDI/SUBI: ENR0 = 1, RDA0 = Rx, BUSSEL = 00, ENA = 1, next T2.
  - NOP: DONE = 1, next T0.
- T2 (BUSY = 1), next T3:
  - ADD/SUB: ENR0 = 1, RDA0 = Ry, BUSSEL = 00, ENG = 1, ALUOP = opcode[0].
  - ADDI/SUBI: BUSSEL = 11, ENG = 1, ALUOP = opcode[0].
- T3 (BUSY = 1): BUSSEL = 10, ENW = 1, WRA = Rx, DONE = 1, next T0.
- Latency from the EXEC-sampling edge:
  - LOAD/COPY/NOP: DONE in the following cycle (2 cycles total).
  - ALU operations: DONE in the 4th cycle.
- EXEC while BUSY is ignored.
  - EXEC held high continuously captures a new instruction in the cycle after DONE, i.e. back-to-back issue with one T0 cycle.
- INSTR changes while BUSY have no effect.
- Self-referencing forms are legal and need no special casing:
  - COPY with Rx = Ry writes the register back to itself.
  - ADD with Rx = Ry gives 2*Rx.
- ENR0 and ENW are never asserted for an address outside 0..3.
- ENR0 = 0 whenever BUSSEL != 00, so the tri-stated Q0 never contends with the bus.
- No ALU arithmetic is done in this block; wrap-around is the ALU's concern.

Test Plan:
- Reset: assert RSTb = 0 mid-T2 of an ADD -> all outputs 0 immediately. After release the block sits in T0 and does not assert ENW until a new EXEC.
- LOAD R2: INSTR = 10'b0000_010_000, EXEC = 1 for one cycle -> the next cycle has ENW = 1, WRA = 2, BUSSEL = 01, DONE = 1. BUSY then returns to 0.
- COPY R3 <- R1: INSTR = 10'b0001_011_001 -> T1 has ENR0 = 1, RDA0 = 1, BUSSEL = 00, ENW = 1, WRA = 3, DONE = 1.
- SUB R0 <- R0 - R2: INSTR = 10'b0011_000_010. Required sequence:
  - T1: RDA0 = 0, ENA = 1.
  - T2: RDA0 = 2, ENG = 1, ALUOP = 1.
  - T3: BUSSEL = 10, ENW = 1, WRA = 0, DONE = 1.
  - Total 4 cycles.
- ADDI R1 += 5: INSTR = 10'b0100_001_101. Required response:
  - T2: BUSSEL = 11, IMM = 10'd5, ALUOP = 0, ENR0 = 0.
  - T3: writes WRA = 1.
  - Toggling INSTR during T1..T3 changes nothing.
- EXEC held high with INSTR = LOAD then undefined opcode 1111 -> LOAD completes, one T0 cycle, then 1111 is captured as a NOP: DONE = 1 in T1, ENW = 0 throughout.
